serializer_tx: RTL and testbench

SERIALIZER_TX -- requirements
Module: serializer_tx

---
 rtl/ser_pkg.sv | 20 ++
 rtl/ser_hold_buf.sv | 34 +++
 rtl/serializer_tx.sv | 139 +++++++++++++
 tb/tb_serializer_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the serializer transmitter.
// Optional feature macro: SER_PARITY_EN (adds the even-parity PARITY state).
package ser_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned GAP_DEF    = 0;
   // Wide enough for the bit index (DATA_W <= 16) and the gap count (GAP <= 15).
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGapWait
`ifdef SER_PARITY_EN
      ,
      StParity
`endif
   } ser_state_e;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer between the parallel handshake and the shifter.
// Optional feature macro: SER_PARITY_EN (not used in this file).
module ser_hold_buf import ser_pkg::*; #(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              take,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] data,
   output logic              valid
);

   logic [DATA_W-1:0] data_q;
   logic              valid_q;

   // A full entry is never overwritten; load only lands in an empty buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (load && !valid_q) begin
         data_q  <= load_data;
         valid_q <= 1'b1;
      end else if (take) begin
         valid_q <= 1'b0;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter, MSB first, with optional inter-frame gap.
// Optional feature macro: SER_PARITY_EN appends one even-parity bit per frame.
module serializer_tx import ser_pkg::*; #(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned GAP    = GAP_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              serial_out,
   output logic              bit_en,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [CNT_W-1:0] BitLast = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GapLast = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

   ser_state_e        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_data;
   logic              buf_valid;
   logic              load, take;
   logic              frame_end, follow;
`ifdef SER_PARITY_EN
   logic              par_q, par_d;
`endif

   assign data_ready = ~buf_valid;
   assign load       = data_valid & data_ready;
   assign busy       = (state_q != StIdle) | buf_valid;

   ser_hold_buf #(
      .DATA_W (DATA_W)
   ) u_hold_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .take      (take),
      .load_data (data_in),
      .data      (buf_data),
      .valid     (buf_valid)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      take       = 1'b0;
      bit_en     = 1'b0;
      serial_out = 1'b0;
      frame_done = 1'b0;
      frame_end  = 1'b0;
      follow     = 1'b0;
`ifdef SER_PARITY_EN
      par_d      = par_q;
`endif

      unique case (state_q)
         StIdle: follow = 1'b1;
         StShift: begin
            bit_en     = 1'b1;
            serial_out = shift_q[DATA_W-1];
            shift_d    = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == BitLast) begin
`ifdef SER_PARITY_EN
               state_d = StParity;
`else
               frame_done = 1'b1;
               frame_end  = 1'b1;
`endif
            end
         end
`ifdef SER_PARITY_EN
         StParity: begin
            bit_en     = 1'b1;
            serial_out = par_q;
            frame_done = 1'b1;
            frame_end  = 1'b1;
         end
`endif
         StGapWait: begin
            cnt_d = cnt_q + CNT_W'(1);
            // The last gap cycle hands straight to a waiting word, so the line
            // shows exactly GAP disabled cycles between frames.
            if (cnt_q == GapLast) begin
               follow = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (frame_end) begin
         if (GAP > 0) begin
            state_d = StGapWait;
            cnt_d   = '0;
         end else begin
            follow = 1'b1;
         end
      end

      if (follow) begin
         if (buf_valid) begin
            take    = 1'b1;
            shift_d = buf_data;
            cnt_d   = '0;
            state_d = StShift;
`ifdef SER_PARITY_EN
            par_d   = ^buf_data;
`endif
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         shift_q <= '0;
         cnt_q   <= '0;
`ifdef SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_serializer_tx.sv
// Scoreboard bench for serializer_tx: a GAP=0 instance for bit/handshake/reset
// behaviour and a GAP=2 instance for inter-frame spacing.
module tb_serializer_tx;

   localparam int W = 8;
`ifdef SER_PARITY_EN
   localparam int FR = W + 1;
`else
   localparam int FR = W;
`endif

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         data_valid = 1'b0;
   logic         data_ready, serial_out, bit_en, busy, frame_done;

   logic [W-1:0] g_data = '0;
   logic         g_valid = 1'b0;
   logic         g_ready, g_serial, g_bit_en, g_busy, g_done;

   int checks = 0;
   int failures = 0;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0, run_len = 0, max_run = 0, done_cnt = 0, last_done = 0, done_gap = 0;
   int   bits_seen = 0;

   logic            g_mon = 1'b0;
   int              g_en_cnt = 0, g_zeros = 0, g_done_cnt = 0;
   logic [2*FR-1:0] g_bits = '0;

   always #5 clk = ~clk;

   serializer_tx #(
      .DATA_W (W),
      .GAP    (0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .serial_out (serial_out),
      .bit_en     (bit_en),
      .busy       (busy),
      .frame_done (frame_done)
   );

   serializer_tx #(
      .DATA_W (W),
      .GAP    (2)
   ) dut_gap (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (g_data),
      .data_valid (g_valid),
      .data_ready (g_ready),
      .serial_out (g_serial),
      .bit_en     (g_bit_en),
      .busy       (g_busy),
      .frame_done (g_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [FR-1:0] frame_of(input logic [W-1:0] w);
`ifdef SER_PARITY_EN
      return {w, ^w};
`else
      return w;
`endif
   endfunction

   task automatic push_word(input logic [W-1:0] w);
      logic [FR-1:0] f;
      exp_t          e;
      f = frame_of(w);
      for (int i = FR - 1; i >= 0; i--) begin
         e.b    = f[i];
         e.last = (i == 0);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_word(input logic [W-1:0] w);
      int n;
      n = 0;
      @(negedge clk);
      data_in    = w;
      data_valid = 1'b1;
      while (!data_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("send_handshake", data_ready, 1'b1);
      if (data_ready) push_word(w);
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   // Valid held high with fresh data every cycle; only words seen with ready high are expected.
   task automatic stream(input int cycles, output int stalled);
      stalled = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         data_in    = W'($urandom);
         data_valid = 1'b1;
         if (data_ready) push_word(data_in);
         else stalled++;
      end
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_in_time", (n < 400), 1'b1);
   endtask

   task automatic clear_stats();
      max_run  = 0;
      done_cnt = 0;
      done_gap = 0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         if (bit_en) begin
            bits_seen++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            check_eq("sb_nonempty", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check_eq("serial_bit", serial_out, mon_e.b);
               check_eq("frame_done", frame_done, mon_e.last);
            end
            check_eq("busy_while_shift", busy, 1'b1);
         end else begin
            run_len = 0;
            check_eq("idle_outputs_zero", {frame_done, serial_out}, 2'b00);
         end
         if (frame_done) begin
            if (done_cnt > 0) done_gap = cyc - last_done;
            last_done = cyc;
            done_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && g_mon) begin
         if (g_bit_en) begin
            g_bits = {g_bits[2*FR-2:0], g_serial};
            g_en_cnt++;
         end else if (g_en_cnt > 0 && g_en_cnt < 2 * FR) begin
            g_zeros++;
         end
         if (g_done) g_done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalled;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ready", data_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_outputs", {bit_en, serial_out, frame_done}, 3'b000);
      rst_n = 1'b1;

      // Single word, MSB first
      clear_stats();
      send_word(8'hA5);
      wait_idle();
      check_eq("a5_busy_after", busy, 1'b0);
      check_eq("a5_ready_after", data_ready, 1'b1);
      check_eq("a5_done_count", done_cnt, 1);
      check_eq("a5_run_len", max_run, FR);

      // Back-to-back with GAP=0: contiguous enables
      clear_stats();
      send_word(8'h3C);
      send_word(8'hC3);
      wait_idle();
      check_eq("b2b_run_len", max_run, 2 * FR);
      check_eq("b2b_done_count", done_cnt, 2);
      check_eq("b2b_done_spacing", done_gap, FR);

      // Parity-sensitive words (plain frames when parity is compiled out)
      send_word(8'h07);
      send_word(8'h03);
      wait_idle();

      // Valid held with changing data while a frame shifts and the buffer is full
      send_word(8'h12);
      stream(30, stalled);
      check_eq("ready_low_seen", (stalled > 0), 1'b1);
      wait_idle();
      check_eq("stream_sb_empty", exp_q.size(), 0);

      // Asynchronous reset mid-frame
      send_word(8'hFF);
      bits_seen = 0;
      n = 0;
      while (bits_seen < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("three_bits_seen", (bits_seen >= 3), 1'b1);
      @(posedge clk);
      #2;
      check_eq("pre_rst_bit_en", bit_en, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_bit_en", bit_en, 1'b0);
      check_eq("async_rst_serial", serial_out, 1'b0);
      check_eq("async_rst_ready", data_ready, 1'b1);
      check_eq("async_rst_busy", busy, 1'b0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_ready", data_ready, 1'b1);
      check_eq("post_rst_no_resume", bit_en, 1'b0);
      clear_stats();
      send_word(8'h81);
      wait_idle();
      check_eq("post_rst_done_count", done_cnt, 1);
      check_eq("post_rst_sb_empty", exp_q.size(), 0);

      // GAP=2 instance: two queued words, exactly two disabled cycles between frames
      g_mon = 1'b1;
      @(negedge clk);
      g_data  = 8'h5A;
      g_valid = 1'b1;
      @(negedge clk);
      g_data = 8'h96;
      n = 0;
      while (!g_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("gap_second_accept", g_ready, 1'b1);
      @(negedge clk);
      g_valid = 1'b0;
      n = 0;
      while ((g_busy || g_en_cnt < 2 * FR) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("gap_enable_count", g_en_cnt, 2 * FR);
      check_eq("gap_zero_cycles", g_zeros, 2);
      check_eq("gap_done_count", g_done_cnt, 2);
      check_eq("gap_bits", g_bits, {frame_of(8'h5A), frame_of(8'h96)});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
